// File: rtl/rv0_core_pkg.sv
// Shared core types: opcode constants, operand-select enums and the issue buffer entry.
package rv0_core_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;
  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_e;
  typedef enum logic       {OP2_RS2, OP2_IMM} op2_sel_e;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            r1_reg;
    logic            r2_reg;
  } issue_entry_t;

  // Overwrite any register-sourced operand that the current writeback targets.
  function automatic issue_entry_t snoop(issue_entry_t e, logic wv, logic [4:0] wa,
                                         logic [XLEN-1:0] wd);
    issue_entry_t s;
    s = e;
    if (wv && wa != 5'd0) begin
      if (e.r1_reg && e.rs1 == wa) s.r1 = wd;
      if (e.r2_reg && e.rs2 == wa) s.r2 = wd;
    end
    return s;
  endfunction

endpackage

// File: rtl/rv0_imm_gen.sv
// Immediate generator: instruction bits + format select -> sign-extended XLEN immediate.
module rv0_imm_gen
  import rv0_core_pkg::*;
(
  input  logic [31:7]     insn,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{20{insn[31]}}, insn[31:20]};
      IMM_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U: imm = {insn[31:12], 12'b0};
      IMM_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv0_alu_issue.sv
// ALU issue stage: two-entry elastic buffer (head + skid) with operand formation at accept
// and writeback snooping on buffered register operands.
module rv0_alu_issue
  import rv0_core_pkg::*;
#(
  parameter int          XLEN_P   = 32,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ifu_valid_i,
  output logic              ifu_ready_o,
  input  logic [31:0]       ifu_insn_i,
  input  logic [XLEN_P-1:0] ifu_pc_i,
  output logic [4:0]        rf_raddr1_o,
  output logic [4:0]        rf_raddr2_o,
  input  logic [XLEN_P-1:0] rf_rdata1_i,
  input  logic [XLEN_P-1:0] rf_rdata2_i,
  input  logic              wb_valid_i,
  input  logic [4:0]        wb_waddr_i,
  input  logic [XLEN_P-1:0] wb_wdata_i,
  input  logic              flush_i,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  output logic [31:0]       alu_insn_o,
  output logic [XLEN_P-1:0] alu_rdata1_o,
  output logic [XLEN_P-1:0] alu_rdata2_o,
  output logic [XLEN_P-1:0] alu_pc_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]      state_q, state_d;
  issue_entry_t    head_q, head_d, skid_q, skid_d;
  issue_entry_t    head_snp, skid_snp, new_entry;
  imm_type_e       imm_type;
  op1_sel_e        op1_sel;
  op2_sel_e        op2_sel;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  logic            accept, pop;

  assign rf_raddr1_o = ifu_insn_i[19:15];
  assign rf_raddr2_o = ifu_insn_i[24:20];

  always_comb begin
    imm_type = IMM_I;
    op1_sel  = OP1_RS1;
    op2_sel  = OP2_RS2;
    case (ifu_insn_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: op2_sel = OP2_IMM;
      OPC_STORE: begin
        op2_sel  = OP2_IMM;
        imm_type = IMM_S;
      end
      OPC_LUI: begin
        op1_sel  = OP1_ZERO;
        op2_sel  = OP2_IMM;
        imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        op1_sel  = OP1_PC;
        op2_sel  = OP2_IMM;
        imm_type = IMM_U;
      end
      OPC_JAL: begin
        op1_sel  = OP1_PC;
        op2_sel  = OP2_IMM;
        imm_type = IMM_J;
      end
      OPC_BRANCH: begin
        op1_sel  = OP1_PC;
        op2_sel  = OP2_IMM;
        imm_type = IMM_B;
      end
      default: ;
    endcase
  end

  rv0_imm_gen u_imm_gen (
    .insn     (ifu_insn_i[31:7]),
    .imm_type (imm_type),
    .imm      (imm)
  );

  // x0 is hardwired; a same-cycle writeback beats the regfile read.
  function automatic logic [XLEN-1:0] reg_val(logic [4:0] idx, logic [XLEN-1:0] rf);
    if (idx == 5'd0) return '0;
    if (wb_valid_i && wb_waddr_i == idx) return wb_wdata_i;
    return rf;
  endfunction

  assign rs1_val = reg_val(rf_raddr1_o, rf_rdata1_i);
  assign rs2_val = reg_val(rf_raddr2_o, rf_rdata2_i);

  always_comb begin
    new_entry        = '0;
    new_entry.insn   = ifu_insn_i;
    new_entry.pc     = ifu_pc_i;
    new_entry.rs1    = rf_raddr1_o;
    new_entry.rs2    = rf_raddr2_o;
    new_entry.r1_reg = (op1_sel == OP1_RS1);
    new_entry.r2_reg = (op2_sel == OP2_RS2);
    case (op1_sel)
      OP1_PC:   new_entry.r1 = ifu_pc_i;
      OP1_ZERO: new_entry.r1 = '0;
      default:  new_entry.r1 = rs1_val;
    endcase
    new_entry.r2 = new_entry.r2_reg ? rs2_val : imm;
  end

  assign accept = ifu_valid_i & ifu_ready_o;
  assign pop    = alu_valid_o & alu_ready_i;

  assign head_snp = snoop(head_q, wb_valid_i, wb_waddr_i, wb_wdata_i);
  assign skid_snp = snoop(skid_q, wb_valid_i, wb_waddr_i, wb_wdata_i);

  always_comb begin
    state_d = state_q;
    head_d  = head_snp;
    skid_d  = skid_snp;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (accept) begin
          state_d = S_ONE;
          head_d  = new_entry;
        end
        S_ONE: begin
          if (accept && pop) begin
            head_d = new_entry;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = new_entry;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: if (pop) begin
          state_d = S_ONE;
          head_d  = skid_snp;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      ifu_ready_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      ifu_ready_o <= (state_d != S_FULL);
    end
  end

  assign alu_valid_o  = (state_q != S_EMPTY);
  assign alu_insn_o   = alu_valid_o ? head_q.insn : NOP_INSN;
  assign alu_rdata1_o = alu_valid_o ? head_q.r1   : '0;
  assign alu_rdata2_o = alu_valid_o ? head_q.r2   : '0;
  assign alu_pc_o     = alu_valid_o ? head_q.pc   : '0;

endmodule

// File: tb/tb_rv0_alu_issue.sv
// Scoreboard bench for rv0_alu_issue: directed scenarios plus randomized traffic with
// random backpressure, writebacks and flushes against an architectural register model.
module tb_rv0_alu_issue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 0, rst_ni = 0;
  logic        ifu_valid_i = 0, ifu_ready_o;
  logic [31:0] ifu_insn_i = 0, ifu_pc_i = 0;
  logic [4:0]  rf_raddr1_o, rf_raddr2_o;
  logic [31:0] rf_rdata1_i, rf_rdata2_i;
  logic        wb_valid_i = 0;
  logic [4:0]  wb_waddr_i = 0;
  logic [31:0] wb_wdata_i = 0;
  logic        flush_i = 0, alu_valid_o, alu_ready_i = 1;
  logic [31:0] alu_insn_o, alu_rdata1_o, alu_rdata2_o, alu_pc_o;

  int checks = 0, errors = 0;
  logic [31:0] regs [32] = '{default: 32'h0};
  logic [63:0] sb_q[$];   // {insn, pc} in program order
  logic        bg_en = 0;

  always #5 clk = ~clk;

  rv0_alu_issue dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ifu_valid_i(ifu_valid_i), .ifu_ready_o(ifu_ready_o),
    .ifu_insn_i(ifu_insn_i), .ifu_pc_i(ifu_pc_i),
    .rf_raddr1_o(rf_raddr1_o), .rf_raddr2_o(rf_raddr2_o),
    .rf_rdata1_i(rf_rdata1_i), .rf_rdata2_i(rf_rdata2_i),
    .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .flush_i(flush_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_insn_o(alu_insn_o), .alu_rdata1_o(alu_rdata1_o),
    .alu_rdata2_o(alu_rdata2_o), .alu_pc_o(alu_pc_o)
  );

  // Regfile model; x0 returns junk so the stage must zero it itself.
  assign rf_rdata1_i = (rf_raddr1_o == 0) ? 32'hDEADBEEF : regs[rf_raddr1_o];
  assign rf_rdata2_i = (rf_raddr2_o == 0) ? 32'hDEADBEEF : regs[rf_raddr2_o];
  always @(posedge clk) if (wb_valid_i && wb_waddr_i != 0) regs[wb_waddr_i] <= wb_wdata_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] arch(input logic [4:0] i);
    return (i == 0) ? 32'h0 : regs[i];
  endfunction

  // Reference operands from the ISA field layout, using the latest architectural registers.
  task automatic ref_ops(input logic [31:0] insn, input logic [31:0] pc,
                         output logic [31:0] e1, output logic [31:0] e2);
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, a, b;
    imm_i = $signed(insn) >>> 20;
    imm_s = (imm_i & ~32'd31) | {27'd0, insn[11:7]};
    imm_b = (imm_s & ~32'h801) | ({31'd0, insn[7]} << 11);
    imm_u = insn & 32'hFFFFF000;
    imm_j = (imm_i & 32'hFFF007FE) | (insn & 32'h000FF000) | ({31'd0, insn[20]} << 11);
    a = arch(insn[19:15]);
    b = arch(insn[24:20]);
    case (insn[6:0])
      7'h13, 7'h03, 7'h67: begin e1 = a;  e2 = imm_i; end
      7'h23:               begin e1 = a;  e2 = imm_s; end
      7'h37:               begin e1 = 0;  e2 = imm_u; end
      7'h17:               begin e1 = pc; e2 = imm_u; end
      7'h6F:               begin e1 = pc; e2 = imm_j; end
      7'h63:               begin e1 = pc; e2 = imm_b; end
      default:             begin e1 = a;  e2 = b;     end
    endcase
  endtask

  // Accept recorder: sample handshake mid-cycle, commit to the queue at the edge.
  logic        snap_acc = 0, snap_flush = 0;
  logic [63:0] snap_ent = 0;
  always @(negedge clk) begin
    snap_acc   = rst_ni && ifu_valid_i && ifu_ready_o && !flush_i;
    snap_flush = rst_ni && flush_i;
    snap_ent   = {ifu_insn_i, ifu_pc_i};
  end
  always @(posedge clk) begin
    if (!rst_ni || snap_flush) sb_q.delete();
    else if (snap_acc) sb_q.push_back(snap_ent);
  end
  always @(negedge rst_ni) sb_q.delete();

  // Monitor: compare head against the model whenever the ALU consumes it.
  logic        prev_hold = 0;
  logic [31:0] prev_insn = 0, prev_pc = 0;
  always @(negedge clk) begin
    logic [63:0] ent;
    logic [31:0] e1, e2;
    if (rst_ni) begin
      chk("valid_vs_model", {31'd0, alu_valid_o}, {31'd0, sb_q.size() != 0});
      chk("ready_vs_model", {31'd0, ifu_ready_o}, {31'd0, sb_q.size() < 2});
      if (!alu_valid_o) chk("idle_insn_nop", alu_insn_o, NOP);
      if (prev_hold && alu_valid_o) begin
        chk("stall_insn_stable", alu_insn_o, prev_insn);
        chk("stall_pc_stable", alu_pc_o, prev_pc);
      end
      if (alu_valid_o && alu_ready_i && sb_q.size() != 0) begin
        ent = sb_q.pop_front();
        ref_ops(ent[63:32], ent[31:0], e1, e2);
        chk("pop_insn", alu_insn_o, ent[63:32]);
        chk("pop_pc", alu_pc_o, ent[31:0]);
        chk("pop_r1", alu_rdata1_o, e1);
        chk("pop_r2", alu_rdata2_o, e2);
      end
      prev_hold = alu_valid_o && !alu_ready_i && !flush_i;
      prev_insn = alu_insn_o;
      prev_pc   = alu_pc_o;
    end else begin
      prev_hold = 0;
    end
  end

  // Random background: backpressure, writebacks (to a small register window) and rare flushes.
  always @(posedge clk) if (bg_en) begin
    #1;
    if (bg_en) begin
      alu_ready_i = ($urandom_range(0, 9) < 7);
      wb_valid_i  = $urandom_range(0, 1);
      wb_waddr_i  = 5'($urandom_range(0, 7));
      wb_wdata_i  = $urandom;
      flush_i     = ($urandom_range(0, 99) < 3);
    end
  end

  // Drive one instruction until accepted (or flushed away); called at posedge+1.
  task automatic issue(input logic [31:0] insn, input logic [31:0] pc);
    logic done = 0;
    ifu_valid_i = 1; ifu_insn_i = insn; ifu_pc_i = pc;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = ifu_ready_o || flush_i;
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout: insn %08h never accepted", insn);
    end
    ifu_valid_i = 0;
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    wb_valid_i = 1; wb_waddr_i = a; wb_wdata_i = d;
    @(posedge clk); #1;
    wb_valid_i = 0;
  endtask

  task automatic expect_head(input string name, input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, alu_valid_o}, 32'd1);
    chk({name, "_r1"}, alu_rdata1_o, e1);
    chk({name, "_r2"}, alu_rdata2_o, e2);
  endtask

  initial begin
    logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17,
                              7'h6F, 7'h63, 7'h0F, 7'h73};
    logic [31:0] ri;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, alu_valid_o}, 0);
    chk("rst_insn", alu_insn_o, NOP);
    chk("rst_r1", alu_rdata1_o, 0);
    chk("rst_r2", alu_rdata2_o, 0);
    chk("rst_pc", alu_pc_o, 0);
    chk("rst_ready", {31'd0, ifu_ready_o}, 1);
    rst_ni = 1;
    @(posedge clk); #1;

    // addi x1,x0,-5
    alu_ready_i = 1;
    issue(32'hFFB00093, 32'h100);
    expect_head("addi", 32'h0, 32'hFFFFFFFB);

    // srai x3,x1,4 with x1 = 0x80000000
    set_reg(1, 32'h80000000);
    issue(32'h4040D193, 32'h104);
    expect_head("srai", 32'h80000000, 32'h00000404);
    chk("srai_insn", alu_insn_o, 32'h4040D193);

    // lui / auipc
    issue(32'h12345137, 32'h108);
    expect_head("lui", 32'h0, 32'h12345000);
    @(posedge clk); #1;
    issue(32'h00001117, 32'h80);
    expect_head("auipc", 32'h80, 32'h1000);
    @(posedge clk); #1;

    // add x6,x5,x5: accept-time bypass, then resident snoop while stalled
    set_reg(5, 0);
    alu_ready_i = 0;
    wb_valid_i = 1; wb_waddr_i = 5; wb_wdata_i = 32'h1234;
    issue(32'h00528333, 32'h10C);
    wb_valid_i = 0;
    expect_head("byp_accept", 32'h1234, 32'h1234);
    @(posedge clk); #1;
    set_reg(5, 32'h55);
    expect_head("snoop_head", 32'h55, 32'h55);
    @(posedge clk); #1;
    set_reg(0, 32'h99);
    expect_head("snoop_x0", 32'h55, 32'h55);
    @(posedge clk); #1;
    alu_ready_i = 1;
    repeat (2) @(posedge clk);
    #1;

    // backpressure: three back-to-back, third held, then in-order drain
    alu_ready_i = 0;
    issue(32'h00100093, 32'h200);
    issue(32'h00200113, 32'h204);
    @(negedge clk);
    chk("full_ready_low", {31'd0, ifu_ready_o}, 0);
    @(posedge clk); #1;
    fork
      issue(32'h00300193, 32'h208);
      begin repeat (3) @(posedge clk); #1; alu_ready_i = 1; end
    join
    repeat (4) @(posedge clk);
    #1;

    // flush while FULL with a concurrent fetch
    alu_ready_i = 0;
    issue(32'h00400213, 32'h300);
    issue(32'h00500293, 32'h304);
    ifu_valid_i = 1; ifu_insn_i = 32'h00600313; ifu_pc_i = 32'h308; flush_i = 1;
    @(posedge clk); #1;
    ifu_valid_i = 0; flush_i = 0;
    @(negedge clk);
    chk("flush_valid", {31'd0, alu_valid_o}, 0);
    chk("flush_ready", {31'd0, ifu_ready_o}, 1);
    chk("flush_insn", alu_insn_o, NOP);
    alu_ready_i = 1;
    @(posedge clk); #1;

    // async reset mid-stream
    alu_ready_i = 0;
    issue(32'h00700393, 32'h400);
    issue(32'h00800413, 32'h404);
    #2 rst_ni = 0;
    #1;
    chk("arst_valid", {31'd0, alu_valid_o}, 0);
    chk("arst_insn", alu_insn_o, NOP);
    chk("arst_ready", {31'd0, ifu_ready_o}, 1);
    chk("arst_r2", alu_rdata2_o, 0);
    @(posedge clk); #3 rst_ni = 1;
    @(posedge clk); #1;

    // randomized traffic
    bg_en = 1;
    for (int i = 0; i < 300; i++) begin
      ri = $urandom;
      ri[6:0]   = opcs[$urandom_range(0, 10)];
      ri[19:15] = 5'($urandom_range(0, 7));
      ri[24:20] = 5'($urandom_range(0, 7));
      issue(ri, $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    bg_en = 0;
    @(posedge clk); #1;
    alu_ready_i = 1; wb_valid_i = 0; flush_i = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
